// File: rtl/mod_n_sequence_decoder.sv
// Receive-side decoder for a mod-N up/down counter stream: classifies each
// sampled step as UP, DOWN, HOLD or ERROR and tracks lock and an error count.
module mod_n_sequence_decoder #(
    parameter int WIDTH    = 3,
    parameter int N        = 6,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_Q,
    output logic             o_up,
    output logic             o_down,
    output logic             o_hold,
    output logic             o_err,
    output logic             o_wrap,
    output logic             o_locked,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int               RUN_W   = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] Q_LAST  = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_EXT   = (WIDTH + 1)'(N);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_UNSYNC,
        ST_TRACK_UP,
        ST_TRACK_DOWN,
        ST_TRACK_HOLD,
        ST_ERROR
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] cnt);
        return (cnt == ERR_MAX) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] cnt);
        return (cnt >= RUN_MAX) ? RUN_MAX : cnt + 1'b1;
    endfunction

    // N need not be a power of two, so the wrap points are compared explicitly.
    function automatic logic [WIDTH-1:0] succ_mod_n(input logic [WIDTH-1:0] val);
        return (val == Q_LAST) ? '0 : val + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] pred_mod_n(input logic [WIDTH-1:0] val);
        return (val == '0) ? Q_LAST : val - 1'b1;
    endfunction

    state_t           state_p1, state_nxt;
    logic [WIDTH-1:0] prev_p1, prev_nxt;
    logic [RUN_W-1:0] run_p1, run_nxt;
    logic             up_nxt, down_nxt, hold_nxt, err_nxt, wrap_nxt, locked_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;

    // Stage p0: sample decode against the held reference
    logic             vld_p0;
    logic [WIDTH-1:0] q_p0;
    logic             in_range_p0;
    logic             is_hold_p0, is_up_p0, is_down_p0;

    assign vld_p0      = i_valid;
    assign q_p0        = i_Q;
    assign in_range_p0 = ({1'b0, q_p0} < N_EXT);
    assign is_hold_p0  = (q_p0 == prev_p1);
    assign is_up_p0    = (q_p0 == succ_mod_n(prev_p1));
    assign is_down_p0  = (q_p0 == pred_mod_n(prev_p1));

    always_comb begin
        state_nxt   = state_p1;
        prev_nxt    = prev_p1;
        run_nxt     = run_p1;
        up_nxt      = o_up;
        down_nxt    = o_down;
        hold_nxt    = o_hold;
        err_nxt     = 1'b0;
        wrap_nxt    = 1'b0;
        locked_nxt  = o_locked;
        err_cnt_nxt = o_err_count;

        if (vld_p0) begin
            if (!in_range_p0) begin
                state_nxt   = ST_UNSYNC;
                err_nxt     = 1'b1;
                err_cnt_nxt = sat_inc_err(o_err_count);
                run_nxt     = '0;
                locked_nxt  = 1'b0;
                up_nxt      = 1'b0;
                down_nxt    = 1'b0;
                hold_nxt    = 1'b0;
            end else if (state_p1 == ST_UNSYNC) begin
                state_nxt  = ST_TRACK_HOLD;
                prev_nxt   = q_p0;
                run_nxt    = '0;
                locked_nxt = 1'b0;
                up_nxt     = 1'b0;
                down_nxt   = 1'b0;
                hold_nxt   = 1'b0;
            end else begin
                prev_nxt = q_p0;
                up_nxt   = 1'b0;
                down_nxt = 1'b0;
                hold_nxt = 1'b0;
                // HOLD outranks UP, UP outranks DOWN (resolves the N=2 overlap)
                if (is_hold_p0 || is_up_p0 || is_down_p0) begin
                    run_nxt    = sat_inc_run(run_p1);
                    locked_nxt = (sat_inc_run(run_p1) >= RUN_MAX);
                    if (is_hold_p0) begin
                        state_nxt = ST_TRACK_HOLD;
                        hold_nxt  = 1'b1;
                    end else if (is_up_p0) begin
                        state_nxt = ST_TRACK_UP;
                        up_nxt    = 1'b1;
                        wrap_nxt  = (prev_p1 == Q_LAST);
                    end else begin
                        state_nxt = ST_TRACK_DOWN;
                        down_nxt  = 1'b1;
                        wrap_nxt  = (prev_p1 == '0);
                    end
                end else begin
                    state_nxt   = ST_ERROR;
                    err_nxt     = 1'b1;
                    err_cnt_nxt = sat_inc_err(o_err_count);
                    run_nxt     = '0;
                    locked_nxt  = 1'b0;
                end
            end
        end
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_p1 <= ST_UNSYNC;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_p1     <= '0;
            run_p1      <= '0;
            o_up        <= 1'b0;
            o_down      <= 1'b0;
            o_hold      <= 1'b0;
            o_err       <= 1'b0;
            o_wrap      <= 1'b0;
            o_locked    <= 1'b0;
            o_err_count <= '0;
        end else begin
            prev_p1     <= prev_nxt;
            run_p1      <= run_nxt;
            o_up        <= up_nxt;
            o_down      <= down_nxt;
            o_hold      <= hold_nxt;
            o_err       <= err_nxt;
            o_wrap      <= wrap_nxt;
            o_locked    <= locked_nxt;
            o_err_count <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mod_n_sequence_decoder.sv
// Scoreboard bench for mod_n_sequence_decoder: a modular-arithmetic reference
// model predicts each cycle's outputs; a monitor compares them one cycle later.
module tb_mod_n_sequence_decoder;

    localparam int WIDTH    = 3;
    localparam int N        = 6;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic [WIDTH-1:0] i_Q = '0;
    logic             o_up, o_down, o_hold, o_err, o_wrap, o_locked;
    logic [ERR_W-1:0] o_err_count;

    mod_n_sequence_decoder #(
        .WIDTH(WIDTH), .N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_Q(i_Q),
        .o_up(o_up), .o_down(o_down), .o_hold(o_hold), .o_err(o_err),
        .o_wrap(o_wrap), .o_locked(o_locked), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic             up;
        logic             down;
        logic             hold;
        logic             err;
        logic             wrap;
        logic             locked;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: step = (q - prev) mod N; 0 hold, 1 up, N-1 down.
    exp_t cur_exp;
    bit   m_ref;
    int   m_prev;
    int   m_run;
    int   m_errs;

    task automatic model_reset();
        m_ref   = 1'b0;
        m_prev  = 0;
        m_run   = 0;
        m_errs  = 0;
        cur_exp = '0;
    endtask

    task automatic model_step(input bit v, input int q);
        int d;
        cur_exp.err  = 1'b0;
        cur_exp.wrap = 1'b0;
        if (!v) return;
        if (q >= N) begin
            m_ref  = 1'b0;
            m_run  = 0;
            m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : m_errs;
            cur_exp.err = 1'b1;
            {cur_exp.up, cur_exp.down, cur_exp.hold, cur_exp.locked} = 4'b0000;
        end else if (!m_ref) begin
            m_ref  = 1'b1;
            m_prev = q;
            m_run  = 0;
            {cur_exp.up, cur_exp.down, cur_exp.hold, cur_exp.locked} = 4'b0000;
        end else begin
            d = (q - m_prev + N) % N;
            {cur_exp.up, cur_exp.down, cur_exp.hold} = 3'b000;
            if (d == 0 || d == 1 || d == N - 1) begin
                m_run = (m_run < LOCK_CNT) ? m_run + 1 : LOCK_CNT;
                cur_exp.locked = (m_run >= LOCK_CNT);
                if (d == 0)       cur_exp.hold = 1'b1;
                else if (d == 1)  begin cur_exp.up = 1'b1;   cur_exp.wrap = (q < m_prev); end
                else              begin cur_exp.down = 1'b1; cur_exp.wrap = (q > m_prev); end
            end else begin
                m_run  = 0;
                m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : m_errs;
                cur_exp.err    = 1'b1;
                cur_exp.locked = 1'b0;
            end
            m_prev = q;
        end
        cur_exp.cnt = m_errs[ERR_W-1:0];
    endtask

    task automatic send(input bit v, input int q);
        @(negedge i_clk);
        i_valid = v;
        i_Q     = q[WIDTH-1:0];
        model_step(v, q);
        exp_q.push_back(cur_exp);
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            i_valid = 1'($urandom_range(0, 1));
            i_Q     = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            exp_q.push_back(exp_t'(0));
        end
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        model_step(1'b0, 0);
        exp_q.push_back(cur_exp);
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        exp_t act;
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        act = {o_up, o_down, o_hold, o_err, o_wrap, o_locked, o_err_count};
        vectors++;
        if (act !== exp_t'(0)) begin
            miscompares++;
            $display("FAIL async_reset act=%h exp=%h", act, exp_t'(0));
        end
        model_reset();
        hold_reset(2);
    endtask

    function automatic int pick_q();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return (m_prev + 1) % N;
        if (r < 5) return (m_prev + N - 1) % N;
        if (r < 6) return m_prev;
        return $urandom_range(0, (1 << WIDTH) - 1);
    endfunction

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++)
            send($urandom_range(0, 9) != 0, pick_q());
    endtask

    initial begin : monitor
        exp_t e;
        exp_t act;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {o_up, o_down, o_hold, o_err, o_wrap, o_locked, o_err_count};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t act up/dn/hd/er/wr/lk=%b%b%b%b%b%b cnt=%0d exp up/dn/hd/er/wr/lk=%b%b%b%b%b%b cnt=%0d",
                             $time, act.up, act.down, act.hold, act.err, act.wrap, act.locked, act.cnt,
                             e.up, e.down, e.hold, e.err, e.wrap, e.locked, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        int seq_a[] = '{0, 1, 2, 3, 4, 5, 0, 1, 1, 0, 5, 4, 3, 3, 3, 4};
        int seq_b[] = '{2, 3, 5, 0, 1, 2, 3, 4, 7, 2, 3};
        model_reset();
        hold_reset(2);
        foreach (seq_a[i]) send(1'b1, seq_a[i]);
        send(1'b0, 0);
        send(1'b0, 6);
        foreach (seq_b[i]) send(1'b1, seq_b[i]);
        // Long unbroken random stretch drives the error counter into saturation.
        random_run(2500);
        async_reset();
        for (int k = 0; k < 4; k++) begin
            random_run(400);
            async_reset();
        end
        random_run(200);
        repeat (3) @(negedge i_clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
